// File: rtl/window_former_3x3_if.sv
// rtl/window_former_3x3_if.sv - pixel stream, line-buffer RAM and window bundle for window_former_3x3
//
// Signals:
//   pixel_in, pixel_valid      raster pixel stream into the window former
//   ram_addr, ram_write_enable shared address / write strobe to both line RAMs
//   ram_data_in[1:0]           write data: [0] to line RAM 0, [1] to line RAM 1
//   ram_data_out[1:0]          read data from line RAM 0 / line RAM 1
//   window[8:0]                3x3 window, bit 3*dy+dx, bit 8 newest pixel
//   window_valid               window is valid this cycle
//   center_x, center_y         coordinates of the window centre
//   frame_end                  pulse with the last window of a frame
// Modports: slave = window former, master = environment (source + RAMs + sink).
interface window_former_3x3_if #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480
);
    localparam int AddrWidth = $clog2(ImageWidth + 1);
    localparam int RowWidth  = $clog2(ImageHeight + 1);

    logic                 pixel_in;
    logic                 pixel_valid;
    logic [AddrWidth-1:0] ram_addr;
    logic                 ram_write_enable;
    logic [1:0]           ram_data_in;
    logic [1:0]           ram_data_out;
    logic [8:0]           window;
    logic                 window_valid;
    logic [AddrWidth-1:0] center_x;
    logic [RowWidth-1:0]  center_y;
    logic                 frame_end;

    modport slave (
        input  pixel_in, pixel_valid, ram_data_out,
        output ram_addr, ram_write_enable, ram_data_in,
        output window, window_valid, center_x, center_y, frame_end
    );

    modport master (
        output pixel_in, pixel_valid, ram_data_out,
        input  ram_addr, ram_write_enable, ram_data_in,
        input  window, window_valid, center_x, center_y, frame_end
    );
endinterface

// File: rtl/window_former_3x3.sv
// rtl/window_former_3x3.sv - streaming 3x3 binary window generator using two external line RAMs
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   window_former_3x3_if.slave (pixel stream in, line RAM port, window out)
// A pixel accepted in cycle t is window bit 8 with window_valid in cycle t+2.
module window_former_3x3 #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    window_former_3x3_if.slave    bus
);
    localparam int AddrWidth = $clog2(ImageWidth + 1);
    localparam int RowWidth  = $clog2(ImageHeight + 1);

    localparam logic [AddrWidth-1:0] LastCol = AddrWidth'(ImageWidth - 1);
    localparam logic [RowWidth-1:0]  LastRow = RowWidth'(ImageHeight - 1);
    localparam logic [AddrWidth-1:0] ColOne  = AddrWidth'(1);
    localparam logic [AddrWidth-1:0] ColTwo  = AddrWidth'(2);
    localparam logic [RowWidth-1:0]  RowOne  = RowWidth'(1);
    localparam logic [RowWidth-1:0]  RowTwo  = RowWidth'(2);

    // Raster position of the next accepted pixel.
    logic [AddrWidth-1:0] col;
    logic [RowWidth-1:0]  row;

    // Stage 1 context of the pixel accepted last cycle.
    logic                 pix_d1;
    logic                 v1;
    logic [AddrWidth-1:0] col_d1;
    logic [RowWidth-1:0]  row_d1;

    // Window columns: col_a is dx=0 (oldest), col_c is dx=2 (newest).
    // Bit dy of each column: 0 = row r-2, 1 = row r-1, 2 = row r.
    logic [2:0]           col_a;
    logic [2:0]           col_b;
    logic [2:0]           col_c;

    logic                 window_valid_q;
    logic                 frame_end_q;
    logic [AddrWidth-1:0] center_x_q;
    logic [RowWidth-1:0]  center_y_q;

    logic                 window_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (bus.pixel_valid) begin
            if (col == LastCol) begin
                col <= '0;
                row <= (row == LastRow) ? '0 : row + RowOne;
            end else begin
                col <= col + ColOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_d1 <= 1'b0;
            v1     <= 1'b0;
            col_d1 <= '0;
            row_d1 <= '0;
        end else begin
            v1 <= bus.pixel_valid;
            if (bus.pixel_valid) begin
                pix_d1 <= bus.pixel_in;
                col_d1 <= col;
                row_d1 <= row;
            end
        end
    end

    // Only a pixel at column >= 2 of row >= 2 has a full neighbourhood; this
    // also hides whatever stale data the RAMs or shift register still hold.
    assign window_ok = v1 && (col_d1 >= ColTwo) && (row_d1 >= RowTwo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_a          <= '0;
            col_b          <= '0;
            col_c          <= '0;
            window_valid_q <= 1'b0;
            frame_end_q    <= 1'b0;
            center_x_q     <= '0;
            center_y_q     <= '0;
        end else begin
            window_valid_q <= window_ok;
            frame_end_q    <= window_ok && (col_d1 == LastCol) && (row_d1 == LastRow);
            if (v1) begin
                col_a      <= col_b;
                col_b      <= col_c;
                col_c      <= {pix_d1, bus.ram_data_out[0], bus.ram_data_out[1]};
                center_x_q <= col_d1 - ColOne;
                center_y_q <= row_d1 - RowOne;
            end
        end
    end

    // The RAMs latch address and write enable in stage 0 and take the data one
    // cycle later, so the write data is formed in stage 1 from registered
    // sources: pix_d1 and the RAM's own output register. Shifting row r-1 from
    // RAM 0 into RAM 1 moves both line buffers down by one row.
    assign bus.ram_addr         = col;
    assign bus.ram_write_enable = bus.pixel_valid;
    assign bus.ram_data_in      = v1 ? {bus.ram_data_out[0], pix_d1} : 2'b00;

    assign bus.window       = {col_c[2], col_b[2], col_a[2],
                               col_c[1], col_b[1], col_a[1],
                               col_c[0], col_b[0], col_a[0]};
    assign bus.window_valid = window_valid_q;
    assign bus.frame_end    = frame_end_q;
    assign bus.center_x     = center_x_q;
    assign bus.center_y     = center_y_q;
endmodule

// File: tb/tb_window_former_3x3.sv
// tb/tb_window_former_3x3.sv - self-checking bench for window_former_3x3 (4x4 frames)
module tb_window_former_3x3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_former_3x3_if #(.ImageWidth(W), .ImageHeight(H)) bus();

    window_former_3x3 #(.ImageWidth(W), .ImageHeight(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Two 1-bit line RAMs: registered address / write enable, data one cycle later,
    // registered read data (read returns the contents before the pending write).
    logic          mem0 [W];
    logic          mem1 [W];
    logic [AW-1:0] addr_q = '0;
    logic          we_q   = 1'b0;

    always @(posedge clk) begin
        if (we_q) begin
            mem0[addr_q] <= bus.ram_data_in[0];
            mem1[addr_q] <= bus.ram_data_in[1];
        end
        addr_q           <= bus.ram_addr;
        we_q             <= bus.ram_write_enable;
        bus.ram_data_out <= {mem1[bus.ram_addr], mem0[bus.ram_addr]};
    end

    typedef struct {
        int         due;
        logic [8:0] win;
        int         cx;
        int         cy;
        logic       fe;
    } exp_t;

    exp_t       exp_q [$];
    logic [8:0] obs_win [$];
    int         obs_cx [$];
    int         obs_cy [$];
    bit         img [H][W];
    int         mr, mc, cyc;
    bit         prev_v, prev_p;
    int         n_win, n_fe;
    int         checks, errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ports, update the reference model.
    task automatic step(input bit v, input bit p);
        logic [8:0] w;
        bus.pixel_valid = v;
        bus.pixel_in    = p;
        #1;
        chk("ram_we", bus.ram_write_enable, v);
        chk("ram_addr", bus.ram_addr, mc);
        if (prev_v) chk("ram_din0", bus.ram_data_in[0], prev_p);
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("win_valid", bus.window_valid, 1);
            chk("window", bus.window, exp_q[0].win);
            chk("center_x", bus.center_x, exp_q[0].cx);
            chk("center_y", bus.center_y, exp_q[0].cy);
            chk("frame_end", bus.frame_end, exp_q[0].fe);
            void'(exp_q.pop_front());
        end else begin
            chk("win_idle", bus.window_valid, 0);
            chk("fe_idle", bus.frame_end, 0);
        end
        if (bus.window_valid === 1'b1) begin
            n_win++;
            obs_win.push_back(bus.window);
            obs_cx.push_back(int'(bus.center_x));
            obs_cy.push_back(int'(bus.center_y));
        end
        if (bus.frame_end === 1'b1) n_fe++;
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                for (int dy = 0; dy < 3; dy++)
                    for (int dx = 0; dx < 3; dx++)
                        w[3*dy+dx] = img[mr-2+dy][mc-2+dx];
                exp_q.push_back('{due: cyc + 2, win: w, cx: mc - 1, cy: mr - 1,
                                  fe: (mr == H-1 && mc == W-1)});
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
        prev_v = v;
        prev_p = p;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input bit v);
        rst             = 1'b1;
        bus.pixel_valid = v;
        bus.pixel_in    = 1'b1;
        #1;
        chk("rst_we", bus.ram_write_enable, v);
        chk("rst_addr", bus.ram_addr, 0);
        chk("rst_din", bus.ram_data_in, 0);
        chk("rst_valid", bus.window_valid, 0);
        chk("rst_window", bus.window, 0);
        chk("rst_cx", bus.center_x, 0);
        chk("rst_cy", bus.center_y, 0);
        chk("rst_fe", bus.frame_end, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mr = 0;
        mc = 0;
        prev_v = 0;
        exp_q.delete();
        cyc++;
    endtask

    function automatic bit pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return 1'((r + c) & 1);
            default: return 1'($urandom & 1);
        endcase
    endfunction

    // gap: 0 none, 1 idle cycle after every pixel, 2 random idle cycles
    task automatic send_frame(input int kind, input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                step(1'b1, pix(kind, r, c));
                if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0))
                    step(1'b0, 1'($urandom & 1));
            end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic clear_obs();
        obs_win.delete();
        obs_cx.delete();
        obs_cy.delete();
        n_win = 0;
        n_fe  = 0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; mr = 0; mc = 0;
        prev_v = 0; prev_p = 0; n_win = 0; n_fe = 0;
        for (int i = 0; i < W; i++) begin
            mem0[i] = 1'($urandom & 1);
            mem1[i] = 1'($urandom & 1);
        end
        rst = 1'b1;
        bus.pixel_valid = 1'b0;
        bus.pixel_in = 1'b0;
        #2;
        do_reset(1'b0);
        do_reset(1'b1);

        // All-ones frame, continuous.
        clear_obs();
        send_frame(0, 0);
        idle(2);
        chk("ones_count", n_win, 4);
        chk("ones_fe", n_fe, 1);
        if (n_win == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("ones_win", obs_win[i], 9'h1FF);
                chk("ones_cx", obs_cx[i], 1 + (i % 2));
                chk("ones_cy", obs_cy[i], 1 + (i / 2));
            end
        end

        // Checkerboard, continuous then with alternating gaps.
        for (int g = 0; g < 2; g++) begin
            clear_obs();
            send_frame(2, g);
            idle(2);
            chk("chk_count", n_win, 4);
            chk("chk_fe", n_fe, 1);
            if (n_win >= 2) begin
                chk("chk_win11", obs_win[0], 9'b010101010);
                chk("chk_win21", obs_win[1], 9'b101010101);
            end
        end

        // Reset after 6 pixels, and after 11 pixels (one window in flight).
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < (k == 0 ? 6 : 11); i++) step(1'b1, 1'($urandom & 1));
            do_reset(1'b0);
            clear_obs();
            send_frame(1, 0);
            idle(2);
            chk("rst_frame_count", n_win, 4);
            for (int i = 0; i < n_win; i++) chk("rst_frame_win", obs_win[i], 9'h000);
        end

        // Back-to-back frames, ones then zeros.
        clear_obs();
        send_frame(0, 0);
        send_frame(1, 0);
        idle(2);
        chk("b2b_count", n_win, 8);
        chk("b2b_fe", n_fe, 2);
        for (int i = 4; i < n_win; i++) chk("b2b_win2", obs_win[i], 9'h000);

        // Random frames with random gaps.
        clear_obs();
        for (int f = 0; f < 4; f++) send_frame(3, 2);
        idle(3);
        chk("rand_count", n_win, 16);
        chk("rand_fe", n_fe, 4);
        chk("exp_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_former_3x3.md
# window_former_3x3

Streaming 3x3 binary-window generator that reads and writes two external single-bit line-buffer RAMs (one row of `ImageWidth` pixels each, registered address/write-enable, 1-cycle read latency). It accepts one binary pixel per valid cycle in raster order and drives both RAMs through a shared address. Every cycle whose newest pixel completes a full 3x3 neighbourhood, it emits that window. It sits between the binarisation stage and the feature/morphology stages of the image pipeline.

## Interface
- `ImageWidth`, 640: pixels per row; must be at least 3.
- `ImageHeight`, 480: rows per frame; must be at least 3.
- `AddrWidth` (localparam): `$clog2(ImageWidth + 1)`; matches the line-buffer RAM address width.

- `Clock`  in  1  sole clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high.
- `PixelIn`  in  1  binary pixel.
- `PixelValid`  in  1  `PixelIn` is the next raster pixel; gaps are allowed.
- `RamAddr`  out  AddrWidth  shared address to both RAMs; equals the column counter register.
- `RamWriteEnable`  out  1  combinational copy of `PixelValid`.
- `RamDataIn`  out  2  `[0]` feeds line RAM 0, `[1]` feeds line RAM 1; registered.
- `RamDataOut`  in  2  read data from line RAM 0 and line RAM 1.
- `Window`  out  9  bit index = 3*dy + dx. dy=0 is row r-2 and dy=2 is row r. dx=0 is column c-2 and dx=2 is column c. `Window[8]` is the newest pixel; `Window[4]` is the centre.
- `WindowValid`  out  1  `Window` is valid this cycle.
- `CenterX`  out  AddrWidth  column of the centre pixel (c-1).
- `CenterY`  out  $clog2(ImageHeight+1)  row of the centre pixel (r-1).
- `FrameEnd`  out  1  one-cycle pulse, coincident with the last window of a frame.

## Operation
- Column counter `c` (0..W-1) and row counter `r` (0..H-1) advance only on `PixelValid`.
  - `c` wraps from W-1 to 0 and increments `r`.
  - At (W-1, H-1) both counters wrap to 0, so the next pixel is (0,0) of a new frame.
- Stage 0, cycle t, `PixelValid`=1 at (r,c):
  - `RamAddr`=c and `RamWriteEnable`=1.
  - `PixelIn` is captured into `pix_d1`.
  - `c`, `r` and a valid flag `v1` are captured for stage 1.
- Stage 1, cycle t+1:
  - `RamDataOut[0]` = pixel(r-1,c) and `RamDataOut[1]` = pixel(r-2,c). The RAM reads the old contents before the delayed write lands.
  - `RamDataIn` = {`RamDataOut[0]`, `pix_d1`], so the RAMs write the rows down by one line at address c.
  - If `v1`=1, the 3-column shift register shifts in column {pixel(r-2,c), pixel(r-1,c), pix_d1}.
- Output register, cycle t+2:
  - `WindowValid` = `v1` and c ≥ 2 and r ≥ 2.
  - `CenterX` = c-1, `CenterY` = r-1.
  - `FrameEnd` = `WindowValid` and c = W-1 and r = H-1.
- No border padding. Each frame yields exactly (W-2)*(H-2) windows.
- Stale RAM or shift-register content from earlier rows or frames is never exposed, because it is masked by the c ≥ 2 and r ≥ 2 conditions.
- The RAMs are never cleared.

## Timing
- Latency: a pixel accepted in cycle t appears as `Window[8]` with `WindowValid`=1 in cycle t+2.
- Throughput: one pixel per cycle with no backpressure. Input gaps propagate as `WindowValid`=0 cycles.
- `RamWriteEnable` and `RamAddr` are presented in the same cycle. `RamDataIn` is valid in the following cycle, which matches the RAM's registered-write timing.
- Reset values:
  - counters 0, `pix_d1` 0, `v1` 0, shift register 0;
  - `Window` 0, `WindowValid` 0, `CenterX` 0, `CenterY` 0, `FrameEnd` 0;
  - `RamDataIn` 0 and `RamAddr` 0;
  - `RamWriteEnable` follows `PixelValid` even while `Reset` is high.
- Reset mid-frame: in-flight pixels are discarded and no window is emitted for them. The first pixel after `Reset` deasserts is (0,0).
- Row wrap and frame wrap in the same cycle as `PixelValid` are the normal case; there is no bubble between frames.

## Test plan
- W=4, H=4, all-ones frame with continuous valid:
  - exactly 4 windows, each `Window`=9'h1FF;
  - (`CenterX`,`CenterY`) sequence (1,1),(2,1),(1,2),(2,2);
  - `FrameEnd` only with the 4th window.
- W=4, H=4, checkerboard pixel = (r+c)&1:
  - window at centre (1,1) = 9'b010101010;
  - window at centre (2,1) = 9'b101010101.
- RAM port check, W=4:
  - `RamAddr` sequence 0,1,2,3,0,…;
  - `RamWriteEnable` equals `PixelValid` in the same cycle;
  - `RamDataIn[0]` equals the previous cycle's `PixelIn`.
- Same frame as test 2 with `PixelValid` deasserted every other cycle: identical window values and order; each window appears exactly 2 cycles after its final pixel.
- Assert `Reset` after 6 pixels, then send a full all-zero frame: no window is emitted before r=2,c=2 of the new frame, and exactly 4 windows of 9'h000 follow.
- Two back-to-back frames (all-ones, then all-zeros) with no gap: 8 windows total, `FrameEnd` pulses twice, and no 9'h1FF window appears in frame 2.
